// File: rtl/sysbus_pkg.sv
// Shared Sysbus definitions: tag layout, direction/target codes, line geometry
// and the responder state encoding.
package sysbus_pkg;

   localparam int unsigned SYSBUS_DATA_W = 64;
   localparam int unsigned SYSBUS_TAG_W  = 13;
   localparam int unsigned LINE_BYTES    = 64;
   localparam int unsigned SYSBUS_LINE_BEATS = LINE_BYTES / (SYSBUS_DATA_W / 8);

   // Tag field positions: [12] direction, [11:8] target, [7:0] id
   localparam int unsigned TAG_ID_LSB  = 0;
   localparam int unsigned TAG_ID_W    = 8;
   localparam int unsigned TAG_TGT_LSB = 8;
   localparam int unsigned TAG_TGT_W   = 4;
   localparam int unsigned TAG_DIR_BIT = 12;

   localparam logic                 READ   = 1'b1;
   localparam logic                 WRITE  = 1'b0;
   localparam logic [TAG_TGT_W-1:0] MEMORY = 4'h1;

   typedef struct packed {
      logic                 dir;
      logic [TAG_TGT_W-1:0] target;
      logic [TAG_ID_W-1:0]  id;
   } tag_t;

   localparam int unsigned STATE_W = 3;
   localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [STATE_W-1:0] ST_ACK   = 3'd1;
   localparam logic [STATE_W-1:0] ST_WDATA = 3'd2;
   localparam logic [STATE_W-1:0] ST_WAIT  = 3'd3;
   localparam logic [STATE_W-1:0] ST_RESP  = 3'd4;

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response signal bundle; master is the initiator, slave the memory.
interface sysbus_mem_responder_if
   import sysbus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SYSBUS_DATA_W,
   parameter int unsigned TAG_WIDTH  = SYSBUS_TAG_W
);

   logic                  reqcyc;
   logic [DATA_WIDTH-1:0] req;
   logic [TAG_WIDTH-1:0]  reqtag;
   logic                  reqack;
   logic                  respcyc;
   logic [DATA_WIDTH-1:0] resp;
   logic [TAG_WIDTH-1:0]  resptag;
   logic                  respack;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );

endinterface

// File: rtl/sysbus_mem_array.sv
// Backing store: one synchronous write port, one combinational read port, never cleared.
module sysbus_mem_array #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned MEM_WORDS  = 4096,
   parameter int unsigned ADDR_W     = $clog2(MEM_WORDS)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata_c
);

   logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus endpoint: accepts line READ/WRITE requests and returns each
// read line as ascending beats under respcyc/respack flow control.
module sysbus_mem_responder
   import sysbus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = SYSBUS_DATA_W,
   parameter int unsigned TAG_WIDTH  = SYSBUS_TAG_W,
   parameter int unsigned LINE_BEATS = SYSBUS_LINE_BEATS,
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned MEM_WORDS  = 4096
) (
   input logic clk,
   input logic reset,
   sysbus_mem_responder_if.slave bus
);

   localparam int unsigned ADDR_W = $clog2(MEM_WORDS);
   localparam int unsigned BEAT_W = $clog2(LINE_BEATS);
   localparam int unsigned LINE_W = ADDR_W - BEAT_W;
   localparam int unsigned BYTE_W = $clog2(DATA_WIDTH / 8);
   localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
   localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

   logic [STATE_W-1:0]    state_q, state_d;
   logic [LINE_W-1:0]     line_q, line_d;
   tag_t                  tag_q, tag_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic                  reqack_q, reqack_d;
   logic                  respcyc_q, respcyc_d;
   logic [DATA_WIDTH-1:0] resp_q, resp_d;
   logic [TAG_WIDTH-1:0]  resptag_q, resptag_d;
   logic                  mem_we_c;
   logic [DATA_WIDTH-1:0] mem_rdata_c;

   // Next state, counters and registered output values
   always_comb begin
      state_d  = state_q;
      line_d   = line_q;
      tag_d    = tag_q;
      beat_d   = beat_q;
      lat_d    = lat_q;
      mem_we_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.reqcyc) begin
               // Only the line index survives: byte/beat offset bits drop, high bits alias
               line_d  = bus.req[BYTE_W + BEAT_W +: LINE_W];
               tag_d   = tag_t'(bus.reqtag);
               beat_d  = '0;
               lat_d   = '0;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (tag_q.target != MEMORY) begin
               state_d = ST_IDLE;
            end else if (tag_q.dir == READ) begin
               lat_d   = LAT_LOAD;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_WDATA;
            end
         end
         ST_WDATA: begin
            if (bus.reqcyc) begin
               mem_we_c = reset;
               beat_d   = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_WAIT: begin
            // Leave at 1 so the ACK cycle counts toward latency; LATENCY=1 still waits once
            if (lat_q <= LAT_W'(1)) begin
               beat_d  = '0;
               state_d = ST_RESP;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_RESP: begin
            if (bus.respack) begin
               beat_d = beat_q + BEAT_W'(1);
               if (beat_q == LAST_BEAT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      reqack_d  = (state_d == ST_ACK);
      respcyc_d = (state_d == ST_RESP);
      resp_d    = respcyc_d ? mem_rdata_c : '0;
      resptag_d = respcyc_d ? TAG_WIDTH'(tag_d) : '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         line_q    <= '0;
         tag_q     <= '0;
         beat_q    <= '0;
         lat_q     <= '0;
         reqack_q  <= 1'b0;
         respcyc_q <= 1'b0;
         resp_q    <= '0;
         resptag_q <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         tag_q     <= tag_d;
         beat_q    <= beat_d;
         lat_q     <= lat_d;
         reqack_q  <= reqack_d;
         respcyc_q <= respcyc_d;
         resp_q    <= resp_d;
         resptag_q <= resptag_d;
      end
   end

   sysbus_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_WORDS  (MEM_WORDS),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we_c),
      .waddr   ({line_q, beat_q}),
      .wdata   (bus.req),
      .raddr   ({line_q, beat_d}),
      .rdata_c (mem_rdata_c)
   );

   assign bus.reqack  = reqack_q;
   assign bus.respcyc = respcyc_q;
   assign bus.resp    = resp_q;
   assign bus.resptag = resptag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed bench for sysbus_mem_responder: scoreboard of expected beats built from
// a bench-side memory model, checked as beats are accepted.
module tb_sysbus_mem_responder;
   import sysbus_pkg::*;

   localparam int unsigned LAT   = 4;
   localparam int unsigned BEATS = 8;

   typedef struct packed {
      logic [63:0] data;
      logic [12:0] tag;
   } exp_t;

   logic clk;
   logic reset;

   sysbus_mem_responder_if bus ();

   sysbus_mem_responder #(
      .LATENCY   (LAT),
      .MEM_WORDS (4096)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          checks   = 0;
   int          failures = 0;
   exp_t        sb[$];
   logic [63:0] model [4096];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   function automatic logic [12:0] mk_tag(input logic dir, input logic [3:0] tgt, input logic [7:0] id);
      return {dir, tgt, id};
   endfunction

   // First word of the 8-word line holding byte address a, wrapped to the store depth
   function automatic logic [11:0] line_word(input logic [63:0] a);
      logic [63:0] w;
      w = (a >> 3) & 64'h0000_0000_0000_0FF8;
      return 12'(w);
   endfunction

   task automatic push_line(input logic [63:0] addr, input logic [12:0] t);
      logic [11:0] w;
      w = line_word(addr);
      for (int i = 0; i < BEATS; i++) begin
         sb.push_back('{data: model[w + 12'(i)], tag: t});
      end
   endtask

   task automatic wait_first_beat();
      for (int i = 1; i < LAT; i++) begin
         @(negedge clk);
         check("lat_no_resp", 64'(bus.respcyc), 64'd0);
      end
      @(negedge clk);
      check("lat_first_beat", 64'(bus.respcyc), 64'd1);
   endtask

   task automatic write_line(input logic [63:0] addr, input logic [7:0] id, input logic [63:0] d0);
      logic [11:0] w;
      w = line_word(addr);
      bus.reqcyc = 1'b1;
      bus.req    = addr;
      bus.reqtag = mk_tag(WRITE, MEMORY, id);
      @(negedge clk);
      check("wr_reqack", 64'(bus.reqack), 64'd1);
      @(negedge clk);
      check("wr_reqack_pulse", 64'(bus.reqack), 64'd0);
      for (int i = 0; i < BEATS; i++) begin
         bus.req = d0 + 64'(i);
         model[w + 12'(i)] = bus.req;
         @(negedge clk);
      end
      bus.reqcyc = 1'b0;
      bus.req    = '0;
   endtask

   task automatic read_issue(input logic [63:0] addr, input logic [7:0] id);
      logic [12:0] t;
      t = mk_tag(READ, MEMORY, id);
      bus.reqcyc = 1'b1;
      bus.req    = addr;
      bus.reqtag = t;
      @(negedge clk);
      check("rd_reqack", 64'(bus.reqack), 64'd1);
      bus.reqcyc = 1'b0;
      push_line(addr, t);
      wait_first_beat();
   endtask

   // pat 0: respack always 1; pat 1: respack 1,0,0,1,0,0,...
   task automatic recv_line(input int pat, input int nb);
      int          beats = 0;
      int          cyc   = 0;
      int          k     = 0;
      logic        stall = 1'b0;
      logic [63:0] pr    = '0;
      logic [12:0] pt    = '0;
      exp_t        e;
      while (beats < nb && cyc < 64) begin
         bus.respack = (pat == 0) ? 1'b1 : ((k % 3) == 0);
         if (bus.respcyc) begin
            check("no_reqack_in_burst", 64'(bus.reqack), 64'd0);
            if (stall) begin
               check("hold_resp", bus.resp, pr);
               check("hold_resptag", 64'(bus.resptag), 64'(pt));
            end
            if (bus.respack) begin
               check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("beat_data", bus.resp, e.data);
                  check("beat_tag", 64'(bus.resptag), 64'(e.tag));
               end
               beats++;
            end
            stall = !bus.respack;
            pr    = bus.resp;
            pt    = bus.resptag;
            k++;
         end else begin
            stall = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      check("beat_count", 64'(beats), 64'(nb));
      if (nb == int'(BEATS)) begin
         check("resp_end", 64'(bus.respcyc), 64'd0);
      end
      bus.respack = 1'b0;
   endtask

   task automatic quiet_window(input string name);
      logic seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         seen = seen | bus.respcyc | bus.reqack;
      end
      check(name, 64'(seen), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) model[i] = '0;

      // Reset held with a pending request
      reset       = 1'b0;
      bus.reqcyc  = 1'b1;
      bus.req     = 64'h1000;
      bus.reqtag  = mk_tag(READ, MEMORY, 8'h01);
      bus.respack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_reqack", 64'(bus.reqack), 64'd0);
         check("rst_respcyc", 64'(bus.respcyc), 64'd0);
         check("rst_resp", bus.resp, 64'd0);
         check("rst_resptag", 64'(bus.resptag), 64'd0);
      end
      bus.reqcyc = 1'b0;
      reset      = 1'b1;
      @(negedge clk);

      // Write then unaligned read of the same line
      write_line(64'h1000, 8'h02, 64'hA0);
      read_issue(64'h1028, 8'h11);
      recv_line(0, BEATS);

      // Top-of-store line with backpressure
      write_line(64'h7FC0, 8'h03, 64'hC0DE_0000_0000_0010);
      read_issue(64'h7FC0, 8'h12);
      recv_line(1, BEATS);

      // Address above store depth aliases onto the 0x1000 line
      read_issue(64'h9010, 8'h13);
      recv_line(0, BEATS);

      // Request held during a burst is serviced only after returning to IDLE
      read_issue(64'h1000, 8'h21);
      bus.reqcyc = 1'b1;
      bus.req    = 64'h7FC8;
      bus.reqtag = mk_tag(READ, MEMORY, 8'h22);
      recv_line(0, BEATS);
      check("pend_no_ack_idle", 64'(bus.reqack), 64'd0);
      @(negedge clk);
      check("pend_reqack", 64'(bus.reqack), 64'd1);
      bus.reqcyc = 1'b0;
      push_line(64'h7FC8, mk_tag(READ, MEMORY, 8'h22));
      wait_first_beat();
      recv_line(0, BEATS);

      // Non-MEMORY targets: acked once, then dropped
      bus.reqcyc = 1'b1;
      bus.req    = 64'h1000;
      bus.reqtag = mk_tag(READ, 4'h2, 8'h40);
      @(negedge clk);
      check("drop_rd_reqack", 64'(bus.reqack), 64'd1);
      bus.reqcyc = 1'b0;
      quiet_window("drop_rd_quiet");
      bus.reqcyc = 1'b1;
      bus.req    = 64'h1000;
      bus.reqtag = mk_tag(WRITE, 4'h2, 8'h41);
      @(negedge clk);
      check("drop_wr_reqack", 64'(bus.reqack), 64'd1);
      bus.reqcyc = 1'b0;
      quiet_window("drop_wr_quiet");
      read_issue(64'h1000, 8'h42);
      recv_line(0, BEATS);

      // Reset while beat 3 is on the bus, then a fresh full read
      read_issue(64'h1000, 8'h50);
      recv_line(0, 3);
      check("rst_mid_beat3", bus.resp, sb[0].data);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_respcyc", 64'(bus.respcyc), 64'd0);
      check("rst_mid_resp", bus.resp, 64'd0);
      check("rst_mid_resptag", 64'(bus.resptag), 64'd0);
      sb.delete();
      reset = 1'b1;
      read_issue(64'h1000, 8'h51);
      recv_line(0, BEATS);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
